fifo_wr_arbiter: RTL and testbench

- Shares the async FIFO write port (write-side FSM: insert/full/flush) among NREQ parallel requesters.
- Arbitration is round-robin with burst locking. It drives a one-entry registered insert/wdata stage that obeys the FIFO `full` back-pressure.
- Sits in the clk_in domain, directly in front of the write-side FSM and write memory port.

---
 rtl/fifo_wr_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } arb_state_e;

  localparam int unsigned NReqDef  = 4;
  localparam int unsigned BurstDef = 4;

  // Index width that never collapses to zero for a single entry.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned OwnerWDef = idx_width(NReqDef);
  localparam int unsigned CntWDef   = $clog2(BurstDef + 1);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (int'(start_i) + k) % N;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IdxW'(j);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter feeding a one-entry registered FIFO write stage.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ  = NReqDef,
  parameter int unsigned DATAW = 8,
  parameter int unsigned BURST = BurstDef
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATAW-1:0]        req_data,
  output logic [NREQ-1:0]              grant,
  input  logic                         full,
  input  logic                         flush,
  output logic                         insert,
  output logic [DATAW-1:0]             wdata,
  output logic [idx_width(NREQ)-1:0]   owner_id
);

  localparam int unsigned IdxW = idx_width(NREQ);
  localparam int unsigned CntW = $clog2(BURST + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

  arb_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic              insert_q, insert_d;
  logic [DATAW-1:0]  wdata_q, wdata_d;

  logic [DATAW-1:0]  words [NREQ];
  logic [IdxW-1:0]   start;
  logic [NREQ-1:0]   pick_oh;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic              can_load;
  logic              keep;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      words[i] = req_data[i*DATAW +: DATAW];
    end
  end

  // In OWN, last_q always equals the owner, so one picker serves both states.
  assign start = (last_q == LastIdx) ? '0 : last_q + IdxW'(1);

  rr_pick #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_pick (
    .req_i    (req),
    .start_i  (start),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign can_load = (!insert_q || !full) && !flush && rst;
  assign keep     = (state_q == StOwn) && req[owner_q] && (cnt_q < CntW'(BURST));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    insert_d = insert_q;
    wdata_d  = wdata_q;
    grant    = '0;

    if (flush) begin
      // Stage word is dropped; arbitration restarts at requester 0.
      insert_d = 1'b0;
      state_d  = StIdle;
      cnt_d    = '0;
      last_d   = LastIdx;
      owner_d  = '0;
    end else begin
      if (insert_q && !full) begin
        insert_d = 1'b0;
      end
      if (can_load) begin
        if (keep) begin
          grant[owner_q] = 1'b1;
          cnt_d          = cnt_q + CntW'(1);
          insert_d       = 1'b1;
          wdata_d        = words[owner_q];
        end else if (pick_any) begin
          grant    = pick_oh;
          cnt_d    = CntW'(1);
          state_d  = StOwn;
          owner_d  = pick_idx;
          last_d   = pick_idx;
          insert_d = 1'b1;
          wdata_d  = words[pick_idx];
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      last_q   <= LastIdx;
      owner_q  <= '0;
      insert_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      insert_q <= insert_d;
      wdata_q  <= wdata_d;
    end
  end

  assign insert   = insert_q;
  assign wdata    = wdata_q;
  assign owner_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus randomized bench for fifo_wr_arbiter against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DATAW = 8;
  localparam int BURST = 4;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b0;
  logic [3:0]  req      = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic        full  = 1'b0;
  logic        flush = 1'b0;
  logic        insert;
  logic [7:0]  wdata;
  logic [1:0]  owner_id;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit         m_own;
  int         m_owner;
  int         m_last;
  int         m_cnt;
  int         m_owner_id;
  bit         m_ins;
  logic [7:0] m_wdata;
  bit         m_keep;
  int         last_g;
  logic [3:0] g_obs;

  logic       pend  [4];
  logic [7:0] pdata [4];

  fifo_wr_arbiter #(
    .NREQ  (NREQ),
    .DATAW (DATAW),
    .BURST (BURST)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .full     (full),
    .flush    (flush),
    .insert   (insert),
    .wdata    (wdata),
    .owner_id (owner_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] r, input int start);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (start + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
    m_owner_id = 0; m_ins = 0; m_wdata = '0; m_keep = 0;
  endtask

  task automatic model_pick(output int w);
    w = -1;
    m_keep = 0;
    if (!rst || flush) return;
    if (m_ins && full) return;
    if (m_own && req[m_owner] && m_cnt < BURST) begin
      w = m_owner;
      m_keep = 1;
    end else begin
      w = rr(req, m_own ? m_owner + 1 : m_last + 1);
    end
  endtask

  task automatic model_edge(input int w);
    bit canload;
    if (flush) begin
      m_ins = 0; m_own = 0; m_cnt = 0; m_last = NREQ - 1; m_owner_id = 0; m_owner = 0;
      return;
    end
    canload = !m_ins || !full;
    if (m_ins && !full) m_ins = 0;
    if (w >= 0) begin
      if (m_keep) m_cnt++;
      else begin
        m_own = 1; m_owner = w; m_last = w; m_owner_id = w; m_cnt = 1;
      end
      m_ins = 1;
      m_wdata = req_data[w*DATAW +: DATAW];
    end else if (canload) begin
      m_own = 0;
      m_cnt = 0;
    end
  endtask

  // Called just after a rising edge: drive, check grant at the falling edge, clock, check stage.
  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic f, input logic fl);
    int w;
    req = r; req_data = d; full = f; flush = fl;
    @(negedge clk_in);
    model_pick(w);
    g_obs = grant;
    chk("grant", 32'(grant), (w >= 0) ? (32'd1 << w) : 32'd0);
    @(posedge clk_in);
    model_edge(w);
    last_g = w;
    #1;
    chk("insert", 32'(insert), 32'(m_ins));
    chk("wdata", 32'(wdata), 32'(m_wdata));
    chk("owner_id", 32'(owner_id), 32'(m_owner_id));
  endtask

  initial begin
    model_reset();
    req = 4'b1111;
    req_data = 32'h44332211;
    #12;
    chk("rst_insert", 32'(insert), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    req = '0;
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in);
    #1;

    // Single requester latency.
    step(4'b0010, 32'h0000A500, 1'b0, 1'b0);
    chk("single_grant", 32'(g_obs), 32'h2);
    chk("single_insert", 32'(insert), 32'd1);
    chk("single_wdata", 32'(wdata), 32'hA5);
    chk("single_owner", 32'(owner_id), 32'd1);
    step(4'b0000, 32'h0, 1'b0, 1'b0);
    chk("drain_insert", 32'(insert), 32'd0);

    // All four requesting: bursts of four, then wrap.
    step(4'b0000, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) begin
      step(4'b1111, 32'h40302010 + 32'(k) * 32'h01010101, 1'b0, 1'b0);
      chk("rr_pattern", 32'(g_obs), 32'd1 << ((k / 4) % 4));
      chk("rr_insert", 32'(insert), 32'd1);
    end

    // Back-pressure with 3C held in the stage.
    step(4'b1111, 32'h3C3C3C3C, 1'b0, 1'b0);
    chk("full_pre", 32'(wdata), 32'h3C);
    for (int k = 0; k < 2; k++) begin
      step(4'b1111, 32'h55555555, 1'b1, 1'b0);
      chk("full_grant", 32'(g_obs), 32'd0);
      chk("full_hold", 32'(wdata), 32'h3C);
    end
    step(4'b1111, 32'h55555555, 1'b0, 1'b0);
    chk("full_release_grant", 32'(g_obs), 32'h1);
    chk("full_release_wdata", 32'(wdata), 32'h55);

    // Owner 2 drops after two words; 0 and 3 pending.
    step(4'b0000, 32'h0, 1'b0, 1'b1);
    step(4'b0100, 32'h002A0000, 1'b0, 1'b0);
    step(4'b0100, 32'h002B0000, 1'b0, 1'b0);
    chk("own2", 32'(owner_id), 32'd2);
    step(4'b1001, 32'h3A00000A, 1'b0, 1'b0);
    chk("rot_to3", 32'(g_obs), 32'h8);
    step(4'b0001, 32'h0000000A, 1'b0, 1'b0);
    chk("rot_to0", 32'(g_obs), 32'h1);

    // Flush mid-burst.
    step(4'b1111, 32'h77665544, 1'b0, 1'b0);
    step(4'b1111, 32'h77665544, 1'b0, 1'b1);
    chk("flush_grant", 32'(g_obs), 32'd0);
    chk("flush_insert", 32'(insert), 32'd0);
    step(4'b1111, 32'h77665544, 1'b0, 1'b0);
    chk("flush_restart", 32'(g_obs), 32'h1);

    // Reset mid-burst, then cold-start behaviour again.
    step(4'b1111, 32'h99887766, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mrst_insert", 32'(insert), 32'd0);
    chk("mrst_wdata", 32'(wdata), 32'd0);
    chk("mrst_owner", 32'(owner_id), 32'd0);
    chk("mrst_grant", 32'(grant), 32'd0);
    req = '0;
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    step(4'b0010, 32'h0000A500, 1'b0, 1'b0);
    chk("mrst_single_grant", 32'(g_obs), 32'h2);
    chk("mrst_single_wdata", 32'(wdata), 32'hA5);
    chk("mrst_single_owner", 32'(owner_id), 32'd1);

    // Randomized traffic: requests held until granted.
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      pdata[i] = 8'($urandom);
    end
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  r;
      logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          pdata[i] = 8'($urandom);
        end
        r[i] = pend[i];
        d[i*8 +: 8] = pdata[i];
      end
      step(r, d, ($urandom % 4) == 0, ($urandom % 50) == 0);
      if (last_g >= 0) begin
        pend[last_g] = 1'($urandom % 2);
        pdata[last_g] = 8'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
